// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one 0..N delay timer among NREQ requesters.
// The granted requester receives a one-cycle done pulse after N+1 RUN cycles.
module delay_arbiter #(
    parameter int N     = 20000,
    parameter int CBITS = 15,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [CBITS-1:0] cnt,
    output logic             err
);

    localparam int PBITS = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] CNT_MAX = CBITS'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PBITS-1:0] ptr, ptr_nxt;
    logic [NREQ-1:0]  gnt_nxt, done_nxt;
    logic [CBITS-1:0] cnt_nxt;
    logic             err_nxt;

    logic             pick_valid;
    logic [NREQ-1:0]  pick_onehot;
    logic [PBITS-1:0] pick_succ;
    logic [PBITS-1:0] scan_idx;

    // Round-robin search starting at ptr; the first set request wins.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_valid  = 1'b0;
        pick_onehot = '0;
        pick_succ   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PBITS'((int'(ptr) + k) % NREQ);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid            = 1'b1;
                pick_onehot[scan_idx] = 1'b1;
                pick_succ             = PBITS'((int'(scan_idx) + 1) % NREQ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        err_nxt   = err | (cnt > CNT_MAX);

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = RUN;
                    gnt_nxt   = pick_onehot;
                    cnt_nxt   = '0;
                    ptr_nxt   = pick_succ;
                end
            end
            RUN: begin
                // Terminal count wins over a same-cycle cancel, so done is never lost.
                if (cnt >= CNT_MAX) begin
                    state_nxt = DONE;
                    done_nxt  = gnt;
                    cnt_nxt   = '0;
                end else if ((req & gnt) == '0) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            cnt   <= '0;
            ptr   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            err   <= err_nxt;
        end
    end

    assign busy = (state != IDLE);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_done_with_gnt: assert property (@(posedge clk) disable iff (rst) (done & ~gnt) == '0);
    a_no_err: assert property (@(posedge clk) disable iff (rst) !err);

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter (N=5, CBITS=3, NREQ=4): grant/done events
// are queued with their expected cycle and checked by an independent monitor.
module tb_delay_arbiter;

    localparam int N     = 5;
    localparam int CBITS = 3;
    localparam int NREQ  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  gnt, done;
    logic             busy;
    logic [CBITS-1:0] cnt;
    logic             err;

    delay_arbiter #(.N(N), .CBITS(CBITS), .NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt),
        .err  (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit is_done;
        int idx;
        int at;
    } ev_t;

    ev_t sb[$];

    task automatic expect_ev(input bit is_done, input int idx, input int at);
        ev_t e;
        e.is_done = is_done;
        e.idx     = idx;
        e.at      = at;
        sb.push_back(e);
    endtask

    // Monitor: a grant rise or a done pulse pops the next expected event.
    logic [NREQ-1:0] prev_gnt = '0;
    ev_t             mon_e;
    always @(negedge clk) begin
        if (gnt != '0 && gnt != prev_gnt) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(gnt), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("grant_kind", 32'(mon_e.is_done), 32'd0);
                check("grant_idx", 32'(gnt), 32'd1 << mon_e.idx);
                check("grant_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
        if (done != '0) begin
            check("done_has_gnt", 32'(done & ~gnt), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_kind", 32'(mon_e.is_done), 32'd1);
                check("done_idx", 32'(done), 32'd1 << mon_e.idx);
                check("done_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
        prev_gnt = gnt;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int c;

    initial begin
        // Reset values
        tick(2);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single requester 2: grant next cycle, cnt 0..5, done 7 cycles after sampling
        tick(1);
        c = cyc;
        req = 4'b0100;
        expect_ev(1'b0, 2, c + 1);
        expect_ev(1'b1, 2, c + 7);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("t1_cnt", 32'(cnt), 32'(k - 1));
            check("t1_busy", 32'(busy), 32'd1);
        end
        tick(1);
        check("t1_done_cnt", 32'(cnt), 32'd0);
        req = 4'b0000;
        tick(1);
        check("t1_gnt_fall", 32'(gnt), 32'd0);
        check("t1_busy_fall", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // Re-reset so ptr starts at 0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // All requesting: order 0,1,2,3,0 with grant rises 8 cycles apart
        tick(1);
        c = cyc;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            expect_ev(1'b0, j % NREQ, c + 1 + 8 * j);
            expect_ev(1'b1, j % NREQ, c + 7 + 8 * j);
        end
        tick(39);
        req = 4'b0000;
        tick(1);
        check("t2_idle_gnt", 32'(gnt), 32'd0);

        // Grant to 1 moves ptr to 2; then req=0011 must go to 0
        tick(1);
        c = cyc;
        req = 4'b0010;
        expect_ev(1'b0, 1, c + 1);
        expect_ev(1'b1, 1, c + 7);
        tick(7);
        req = 4'b0011;
        expect_ev(1'b0, 0, c + 9);
        expect_ev(1'b1, 0, c + 15);
        tick(8);
        req = 4'b0000;
        tick(1);

        // Grant to 3, cancel at cnt=2; pending req[0] granted one cycle later
        tick(1);
        c = cyc;
        req = 4'b1000;
        expect_ev(1'b0, 3, c + 1);
        tick(3);
        check("t4_cnt_at_cancel", 32'(cnt), 32'd2);
        req = 4'b0001;
        expect_ev(1'b0, 0, c + 5);
        expect_ev(1'b1, 0, c + 11);
        tick(1);
        check("t4_cancel_gnt", 32'(gnt), 32'd0);
        check("t4_cancel_busy", 32'(busy), 32'd0);
        check("t4_cancel_cnt", 32'(cnt), 32'd0);
        check("t4_cancel_done", 32'(done), 32'd0);
        tick(7);
        req = 4'b0000;
        tick(1);

        // Reset mid-run at cnt=3: reset values, ptr back to 0, no done for the run
        tick(1);
        c = cyc;
        req = 4'b0100;
        expect_ev(1'b0, 2, c + 1);
        tick(4);
        check("t5_cnt_before_rst", 32'(cnt), 32'd3);
        rst = 1'b1;
        tick(1);
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_cnt", 32'(cnt), 32'd0);
        check("t5_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        // ptr=0 picks 0 from 1001; a stale ptr=3 would pick 3
        req = 4'b1001;
        expect_ev(1'b0, 0, c + 6);
        expect_ev(1'b1, 0, c + 12);
        tick(7);
        req = 4'b0000;
        tick(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("final_err", 32'(err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
